// File: rtl/execute_br_queue.sv
// rtl/execute_br_queue.sv - branch execution unit with a small issue queue
// Resolves one queued branch/jump per cycle and broadcasts resolve/kill with its tag.
module execute_br_queue #(
  parameter int XLEN      = 32,
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_REG = 7,
  parameter int DEPTH     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [6:0]           i_uop,
  input  logic [2:0]           i_func3,
  input  logic [XLEN-1:0]      i_op1,
  input  logic [XLEN-1:0]      i_op2,
  input  logic [XLEN-1:0]      i_imm,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [XLEN-1:0]      i_pcnext,
  input  logic [WIDTH_BRM-1:0] i_brtag,
  input  logic [WIDTH_BRM-1:0] i_brmask,
  input  logic [WIDTH_REG-1:0] i_rd,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic                 o_brkill,
  output logic [WIDTH_BRM-1:0] o_brtag,
  output logic [WIDTH_BRM-1:0] o_brmask,
  output logic [XLEN-1:0]      o_pc,
  output logic                 o_we,
  output logic [WIDTH_REG-1:0] o_addr,
  output logic [XLEN-1:0]      o_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [6:0]           q_uop    [DEPTH];
  logic [2:0]           q_func3  [DEPTH];
  logic [XLEN-1:0]      q_op1    [DEPTH];
  logic [XLEN-1:0]      q_op2    [DEPTH];
  logic [XLEN-1:0]      q_imm    [DEPTH];
  logic [XLEN-1:0]      q_pc     [DEPTH];
  logic [XLEN-1:0]      q_pcnext [DEPTH];
  logic [WIDTH_BRM-1:0] q_brtag  [DEPTH];
  logic [WIDTH_BRM-1:0] q_brmask [DEPTH];
  logic [WIDTH_REG-1:0] q_rd     [DEPTH];
  logic [DEPTH-1:0]     q_live;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_next;

  logic                 head_valid, head_live, is_branch, taken, mispredict, head_we;
  logic                 resolve, kill_now, clear_now, accept, drop_in, enq;
  logic [XLEN-1:0]      h_pc, h_op1, h_op2, h_imm, pc_plus4, pc_plus_imm, jalr_sum, target;
  logic [WIDTH_BRM-1:0] h_tag, in_mask;

  always_comb begin
    head_valid  = (count != '0);
    head_live   = head_valid && q_live[rd_ptr];
    h_pc        = q_pc[rd_ptr];
    h_op1       = q_op1[rd_ptr];
    h_op2       = q_op2[rd_ptr];
    h_imm       = q_imm[rd_ptr];
    h_tag       = q_brtag[rd_ptr];
    pc_plus4    = h_pc + XLEN'(4);
    pc_plus_imm = h_pc + h_imm;
    jalr_sum    = h_op1 + h_imm;

    case (q_func3[rd_ptr])
      3'b000:  taken = (h_op1 == h_op2);
      3'b001:  taken = (h_op1 != h_op2);
      3'b100:  taken = ($signed(h_op1) <  $signed(h_op2));
      3'b101:  taken = ($signed(h_op1) >= $signed(h_op2));
      3'b110:  taken = (h_op1 <  h_op2);
      3'b111:  taken = (h_op1 >= h_op2);
      default: taken = 1'b0;
    endcase

    is_branch = 1'b1;
    head_we   = 1'b0;
    case (q_uop[rd_ptr])
      OP_B:    target = taken ? pc_plus_imm : pc_plus4;
      OP_JAL:  begin target = pc_plus_imm; head_we = 1'b1; end
      OP_JALR: begin target = {jalr_sum[XLEN-1:1], 1'b0}; head_we = 1'b1; end
      default: begin target = pc_plus4; is_branch = 1'b0; end
    endcase
    mispredict = is_branch && (target != q_pcnext[rd_ptr]);

    // A flush in the same cycle wins over the head's resolution.
    resolve   = head_live && !i_flush;
    kill_now  = resolve && mispredict;
    clear_now = resolve && !mispredict;

    accept  = i_valid && o_ready && !i_flush;
    drop_in = kill_now && ((i_brmask & h_tag) != '0);
    enq     = accept && !drop_in;
    in_mask = clear_now ? (i_brmask & ~h_tag) : i_brmask;

    if (i_flush) count_next = '0;
    else         count_next = count - (AW+1)'(head_valid) + (AW+1)'(enq);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      q_live   <= '0;
      o_ready  <= 1'b0;
      o_valid  <= 1'b0;
      o_brkill <= 1'b0;
      o_brtag  <= '0;
      o_brmask <= '0;
      o_pc     <= '0;
      o_we     <= 1'b0;
      o_addr   <= '0;
      o_data   <= '0;
    end else if (i_flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_brkill <= 1'b0;
      o_we     <= 1'b0;
    end else begin
      count   <= count_next;
      o_ready <= (count_next != (AW+1)'(DEPTH));
      o_valid <= resolve;
      if (head_valid) rd_ptr <= rd_ptr + AW'(1);

      if (resolve) begin
        o_brkill <= mispredict;
        o_we     <= head_we;
        o_brtag  <= h_tag;
        o_brmask <= q_brmask[rd_ptr];
        o_pc     <= target;
        o_addr   <= q_rd[rd_ptr];
        o_data   <= pc_plus4;
      end else begin
        o_brkill <= 1'b0;
        o_we     <= 1'b0;
      end

      // Dependents of a mispredict die in place and later pop silently.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_now && ((q_brmask[i] & h_tag) != '0)) q_live[i] <= 1'b0;
        else if (clear_now) q_brmask[i] <= q_brmask[i] & ~h_tag;
      end

      if (enq) begin
        q_uop[wr_ptr]    <= i_uop;
        q_func3[wr_ptr]  <= i_func3;
        q_op1[wr_ptr]    <= i_op1;
        q_op2[wr_ptr]    <= i_op2;
        q_imm[wr_ptr]    <= i_imm;
        q_pc[wr_ptr]     <= i_pc;
        q_pcnext[wr_ptr] <= i_pcnext;
        q_brtag[wr_ptr]  <= i_brtag;
        q_brmask[wr_ptr] <= in_mask;
        q_rd[wr_ptr]     <= i_rd;
        q_live[wr_ptr]   <= 1'b1;
        wr_ptr           <= wr_ptr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_execute_br_queue.sv
// tb/tb_execute_br_queue.sv - randomized bench for execute_br_queue
// Reference model keeps the queue as a list of uop records.
module tb_execute_br_queue;

  localparam int XLEN = 32, BRM = 4, REG = 7, DEPTH = 4;
  localparam logic [6:0] OP_B = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic i_clk = 1'b0;
  logic i_rst, i_valid, i_flush, o_ready, o_valid, o_brkill, o_we;
  logic [6:0] i_uop;
  logic [2:0] i_func3;
  logic [XLEN-1:0] i_op1, i_op2, i_imm, i_pc, i_pcnext, o_pc, o_data;
  logic [BRM-1:0] i_brtag, i_brmask, o_brtag, o_brmask;
  logic [REG-1:0] i_rd, o_addr;

  execute_br_queue #(.XLEN(XLEN), .WIDTH_BRM(BRM), .WIDTH_REG(REG), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_uop(i_uop), .i_func3(i_func3), .i_op1(i_op1), .i_op2(i_op2), .i_imm(i_imm),
    .i_pc(i_pc), .i_pcnext(i_pcnext), .i_brtag(i_brtag), .i_brmask(i_brmask),
    .i_rd(i_rd), .i_flush(i_flush), .o_valid(o_valid), .o_brkill(o_brkill),
    .o_brtag(o_brtag), .o_brmask(o_brmask), .o_pc(o_pc), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [6:0] uop; logic [2:0] f3;
    logic [31:0] op1, op2, imm, pc, pcn;
    logic [3:0] tag, mask; logic [6:0] rd; bit live;
  } uop_t;

  uop_t mq[$];
  bit m_ready, m_valid, m_kill, m_we;
  logic [3:0] m_tag, m_mask;
  logic [31:0] m_pc, m_data;
  logic [6:0] m_addr;
  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target(input uop_t u, output bit is_br, output bit we);
    int sa, sb;
    bit t;
    sa = u.op1; sb = u.op2;
    is_br = 1; we = 0;
    case (u.uop)
      OP_B: begin
        case (u.f3)
          3'd0: t = (u.op1 == u.op2);
          3'd1: t = (u.op1 != u.op2);
          3'd4: t = (sa < sb);
          3'd5: t = (sa >= sb);
          3'd6: t = (u.op1 < u.op2);
          3'd7: t = (u.op1 >= u.op2);
          default: t = 0;
        endcase
        return t ? u.pc + u.imm : u.pc + 32'd4;
      end
      OP_JAL:  begin we = 1; return u.pc + u.imm; end
      OP_JALR: begin we = 1; return (u.op1 + u.imm) & 32'hFFFF_FFFE; end
      default: begin is_br = 0; return u.pc + 32'd4; end
    endcase
  endfunction

  task automatic model_step();
    uop_t h, inc;
    bit res, kill, isb, we;
    logic [31:0] tgt;
    if (i_rst) begin
      mq.delete();
      m_ready = 0; m_valid = 0; m_kill = 0; m_we = 0;
      m_tag = 0; m_mask = 0; m_pc = 0; m_addr = 0; m_data = 0;
      return;
    end
    if (i_flush) begin
      mq.delete();
      m_ready = 1; m_valid = 0; m_kill = 0; m_we = 0;
      return;
    end
    res = 0; kill = 0;
    m_valid = 0; m_kill = 0; m_we = 0;
    if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h.live) begin
        res = 1;
        tgt = ref_target(h, isb, we);
        kill = isb && (tgt != h.pcn);
        m_valid = 1; m_kill = kill; m_we = we;
        m_tag = h.tag; m_mask = h.mask; m_pc = tgt; m_addr = h.rd; m_data = h.pc + 32'd4;
      end
    end
    foreach (mq[i]) begin
      if (res && kill && ((mq[i].mask & h.tag) != 0)) mq[i].live = 0;
      else if (res && !kill) mq[i].mask = mq[i].mask & ~h.tag;
    end
    if (i_valid && m_ready) begin
      inc = '{i_uop, i_func3, i_op1, i_op2, i_imm, i_pc, i_pcnext, i_brtag, i_brmask, i_rd, 1'b1};
      if (res && !kill) inc.mask = inc.mask & ~h.tag;
      if (!(res && kill && ((inc.mask & h.tag) != 0))) mq.push_back(inc);
    end
    m_ready = (mq.size() != DEPTH);
  endtask

  task automatic step();
    model_step();
    @(posedge i_clk);
    #1;
    check("ready", o_ready, m_ready);
    check("valid", o_valid, m_valid);
    check("brkill", o_brkill, m_kill);
    check("we", o_we, m_we);
    check("brtag", o_brtag, m_tag);
    check("brmask", o_brmask, m_mask);
    check("pc", o_pc, m_pc);
    check("addr", o_addr, m_addr);
    check("data", o_data, m_data);
  endtask

  task automatic set_uop(input logic [6:0] uop, input logic [2:0] f3, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] pcn, input logic [3:0] tag, input logic [3:0] mask,
                         input logic [6:0] rd);
    i_valid = 1; i_uop = uop; i_func3 = f3; i_op1 = op1; i_op2 = op2; i_imm = imm;
    i_pc = pc; i_pcnext = pcn; i_brtag = tag; i_brmask = mask; i_rd = rd;
  endtask

  initial begin
    logic [31:0] cands [4];
    i_rst = 1; i_flush = 0;
    set_uop(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_valid = 0;
    step(); step();
    check("rst_ready_low", o_ready, 0);
    i_rst = 0;
    step();
    check("ready_after_rst", o_ready, 1);

    set_uop(OP_B, 3'd0, 5, 5, 32'h20, 32'h100, 32'h120, 4'b0001, 4'b0000, 7'd5);
    step();
    i_valid = 0;
    step();
    check("beq_valid", o_valid, 1);
    check("beq_pc", o_pc, 32'h120);
    check("beq_kill", o_brkill, 0);

    set_uop(OP_B, 3'd4, 32'hFFFF_FFFF, 1, 32'h40, 32'h200, 32'h240, 4'b0010, 4'b0000, 7'd1);
    step();
    set_uop(OP_B, 3'd6, 32'hFFFF_FFFF, 1, 32'h40, 32'h200, 32'h240, 4'b0100, 4'b0000, 7'd2);
    step();
    check("blt_pc", o_pc, 32'h240);
    check("blt_kill", o_brkill, 0);
    i_valid = 0;
    step();
    check("bltu_pc", o_pc, 32'h204);
    check("bltu_kill", o_brkill, 1);

    set_uop(OP_JALR, 3'd0, 32'h203, 0, 0, 32'h300, 32'h204, 4'b1000, 4'b0000, 7'd9);
    step();
    i_valid = 0;
    step();
    check("jalr_pc", o_pc, 32'h202);
    check("jalr_kill", o_brkill, 1);
    check("jalr_we", o_we, 1);
    check("jalr_data", o_data, 32'h304);
    check("jalr_addr", o_addr, 9);

    // mispredicting head drops a dependent arriving in the same cycle
    set_uop(OP_B, 3'd0, 1, 2, 32'h10, 32'h400, 32'h410, 4'b0001, 4'b0000, 7'd3);
    step();
    set_uop(OP_JAL, 3'd0, 0, 0, 32'h8, 32'h420, 32'h428, 4'b0010, 4'b0001, 7'd4);
    step();
    check("sq_head_kill", o_brkill, 1);
    set_uop(OP_JAL, 3'd0, 0, 0, 32'h8, 32'h440, 32'h448, 4'b0100, 4'b0010, 7'd6);
    step();
    check("sq_dropped_silent", o_valid, 0);
    i_valid = 0;
    step();
    check("sq_indep_valid", o_valid, 1);
    check("sq_indep_tag", o_brtag, 4'b0100);

    // correct resolve clears its tag from a same-cycle arrival
    set_uop(OP_JAL, 3'd0, 0, 0, 32'h8, 32'h500, 32'h508, 4'b1000, 4'b0000, 7'd7);
    step();
    set_uop(OP_JAL, 3'd0, 0, 0, 32'h8, 32'h600, 32'h608, 4'b0001, 4'b1010, 7'd8);
    step();
    i_valid = 0;
    step();
    check("clr_mask", o_brmask, 4'b0010);

    set_uop(OP_JAL, 3'd0, 0, 0, 32'h8, 32'h700, 32'h708, 4'b0001, 4'b0000, 7'd10);
    step();
    i_flush = 1;
    step();
    check("flush_no_valid", o_valid, 0);
    i_flush = 0; i_valid = 0;
    step();
    check("flush_empty", o_valid, 0);
    set_uop(OP_JAL, 3'd0, 0, 0, 32'h8, 32'h800, 32'h808, 4'b0001, 4'b0000, 7'd11);
    step();
    i_rst = 1; i_flush = 1;
    step();
    check("rst_flush_valid", o_valid, 0);
    check("rst_flush_ready", o_ready, 0);
    i_rst = 0; i_flush = 0; i_valid = 0;
    step();

    for (int c = 0; c < 3000; c++) begin
      i_rst   = ($urandom % 500) == 0;
      i_flush = ($urandom % 40) == 0;
      i_valid = ($urandom % 4) != 0;
      case ($urandom % 4)
        0: i_uop = OP_B;
        1: i_uop = OP_JAL;
        2: i_uop = OP_JALR;
        default: i_uop = 7'h33;
      endcase
      if ($urandom % 2 == 0) i_uop = OP_B;
      i_func3 = 3'($urandom);
      i_op1 = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : 32'($urandom % 3);
      i_op2 = ($urandom % 4 == 0) ? 32'h8000_0000 : 32'($urandom % 3);
      i_imm = 32'($urandom % 64) - 32'd32;
      i_pc = 32'($urandom) & 32'hFFFF_FFFC;
      cands[0] = i_pc + 32'd4;
      cands[1] = i_pc + i_imm;
      cands[2] = (i_op1 + i_imm) & 32'hFFFF_FFFE;
      cands[3] = $urandom;
      i_pcnext = cands[$urandom % 4];
      i_brtag = 4'b0001 << ($urandom % 4);
      i_brmask = 4'($urandom);
      i_rd = 7'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
